// File: rtl/b_mult_sequencer.sv
// b_mult_sequencer
//
// Sequencing controller for the 8x8 Baugh-Wooley array multiplier.
// Operand A (with the signed/unsigned mode) and then operand B are accepted
// over a byte-wide valid/ready port. The operands are registered onto the
// combinational array, which is given SETTLE_CYCLES clock edges to settle.
// The 16-bit product is then captured and returned low byte first over a
// byte-wide valid/ready port.
//
// Optional feature macro: B_MULT_SEQ_CHECK_EN
//   When defined, the array product is compared at capture against a
//   behavioural product, and o_err is set (sticky until reset) on a mismatch.
//   When undefined, o_err is tied low and no checker logic exists.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_ena         design enable; low freezes all state
//   i_in_valid    host presents an operand byte
//   o_in_ready    operand byte accepted this cycle (combinational)
//   i_in_data     operand byte
//   i_in_signed   mode, sampled with operand A (1 = two's complement)
//   o_out_valid   product byte available (combinational)
//   i_out_ready   host consumes the product byte
//   o_out_data    product byte (low byte, then high byte)
//   o_out_last    high with the high product byte
//   o_mul_a/b     registered operands to the array
//   o_mul_signed  registered mode to the array
//   i_mul_p       combinational array product
//   o_busy        high in any state other than LOAD_A
//   o_err         sticky self-check mismatch

module b_mult_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ena,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_signed,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_out_data,
    output logic        o_out_last,
    output logic [7:0]  o_mul_a,
    output logic [7:0]  o_mul_b,
    output logic        o_mul_signed,
    input  logic [15:0] i_mul_p,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [2:0] ST_LOAD_A = 3'd0;
    localparam logic [2:0] ST_LOAD_B = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_OUT_LO = 3'd3;
    localparam logic [2:0] ST_OUT_HI = 3'd4;

    // Counter is loaded at B accept, so capture lands SETTLE_CYCLES edges later.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_prod;
    logic [7:0]  r_mul_a;
    logic [7:0]  r_mul_b;
    logic        r_mul_signed;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_send;
    logic        w_capture;

    assign w_in_ready  = i_ena && ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B));
    assign w_out_valid = i_ena && ((r_state == ST_OUT_LO) || (r_state == ST_OUT_HI));
    assign w_accept    = w_in_ready && i_in_valid;
    assign w_send      = w_out_valid && i_out_ready;
    assign w_capture   = i_ena && (r_state == ST_SETTLE) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_LOAD_A;
            r_cnt        <= 4'd0;
            r_prod       <= 16'h0000;
            r_mul_a      <= 8'h00;
            r_mul_b      <= 8'h00;
            r_mul_signed <= 1'b0;
        end else if (i_ena) begin
            unique case (r_state)
                ST_LOAD_A: begin
                    if (w_accept) begin
                        r_mul_a      <= i_in_data;
                        r_mul_signed <= i_in_signed;
                        r_state      <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_accept) begin
                        r_mul_b <= i_in_data;
                        r_cnt   <= SETTLE_INIT;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_prod  <= i_mul_p;
                        r_state <= ST_OUT_LO;
                    end
                end
                ST_OUT_LO: begin
                    if (w_send) begin
                        r_state <= ST_OUT_HI;
                    end
                end
                ST_OUT_HI: begin
                    if (w_send) begin
                        r_state <= ST_LOAD_A;
                    end
                end
                default: r_state <= ST_LOAD_A;
            endcase
        end
    end

    always_comb begin
        o_out_data = 8'h00;
        o_out_last = 1'b0;
        if (r_state == ST_OUT_LO) begin
            o_out_data = r_prod[7:0];
        end else if (r_state == ST_OUT_HI) begin
            o_out_data = r_prod[15:8];
            o_out_last = 1'b1;
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = w_out_valid;
    assign o_mul_a      = r_mul_a;
    assign o_mul_b      = r_mul_b;
    assign o_mul_signed = r_mul_signed;
    assign o_busy       = (r_state != ST_LOAD_A);

`ifdef B_MULT_SEQ_CHECK_EN
    logic [15:0] w_ext_a;
    logic [15:0] w_ext_b;
    logic [15:0] w_ref_prod;
    logic        r_err;

    // Sign- or zero-extend to 16 bits; the low 16 bits of the product are then
    // correct for both modes.
    assign w_ext_a    = r_mul_signed ? {{8{r_mul_a[7]}}, r_mul_a} : {8'h00, r_mul_a};
    assign w_ext_b    = r_mul_signed ? {{8{r_mul_b[7]}}, r_mul_b} : {8'h00, r_mul_b};
    assign w_ref_prod = w_ext_a * w_ext_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_capture && (i_mul_p != w_ref_prod)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused;
    assign w_unused = w_capture;
    assign o_err    = 1'b0;
`endif

endmodule

// File: tb/tb_b_mult_sequencer.sv
// Self-checking bench for b_mult_sequencer: directed transactions with
// hand-computed expectations, then randomized traffic, all checked every
// cycle against a transaction-level reference model.

module tb_b_mult_sequencer;

    localparam int unsigned SETTLE = 2;

    localparam int PH_A    = 0;
    localparam int PH_B    = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_LO   = 3;
    localparam int PH_HI   = 4;

    logic        clk;
    logic        rst_n;
    logic        i_ena;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_in_data;
    logic        i_in_signed;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_out_data;
    logic        o_out_last;
    logic [7:0]  o_mul_a;
    logic [7:0]  o_mul_b;
    logic        o_mul_signed;
    logic [15:0] i_mul_p;
    logic        o_busy;
    logic        o_err;

    logic        corrupt;
    int          n_checks;
    int          n_errors;

    b_mult_sequencer #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ena       (i_ena),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_signed (i_in_signed),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_mul_a     (o_mul_a),
        .o_mul_b     (o_mul_b),
        .o_mul_signed(o_mul_signed),
        .i_mul_p     (i_mul_p),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
        int x;
        if (s) x = int'($signed(a)) * int'($signed(b));
        else   x = int'(a) * int'(b);
        return 16'(x);
    endfunction

    // Array stand-in; corrupt forces a wrong product.
    always_comb i_mul_p = corrupt ? 16'h0000 : ref_mul(o_mul_a, o_mul_b, o_mul_signed);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at each falling edge; checks outputs, then
    // predicts the effect of the next rising edge from the current inputs.
    initial begin
        int          m_ph;
        int          m_wait;
        logic [7:0]  m_a;
        logic [7:0]  m_b;
        logic        m_s;
        logic [15:0] m_p;
        logic [15:0] m_true;
        logic        m_err;
        logic [7:0]  e_data;
        m_ph = PH_A; m_wait = 0; m_a = 0; m_b = 0; m_s = 0; m_p = 0; m_err = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ph = PH_A; m_wait = 0; m_a = 0; m_b = 0; m_s = 0; m_p = 0; m_err = 0;
            end
            e_data = (m_ph == PH_LO) ? m_p[7:0] : (m_ph == PH_HI) ? m_p[15:8] : 8'h00;
            chk("m_in_ready", 32'(o_in_ready), 32'(i_ena && (m_ph == PH_A || m_ph == PH_B)));
            chk("m_out_valid", 32'(o_out_valid), 32'(i_ena && (m_ph == PH_LO || m_ph == PH_HI)));
            chk("m_out_data", 32'(o_out_data), 32'(e_data));
            chk("m_out_last", 32'(o_out_last), 32'(m_ph == PH_HI));
            chk("m_busy", 32'(o_busy), 32'(m_ph != PH_A));
            chk("m_mul_a", 32'(o_mul_a), 32'(m_a));
            chk("m_mul_b", 32'(o_mul_b), 32'(m_b));
            chk("m_mul_signed", 32'(o_mul_signed), 32'(m_s));
            chk("m_err", 32'(o_err), 32'(m_err));
            if (rst_n && i_ena) begin
                case (m_ph)
                    PH_A: if (i_in_valid) begin
                        m_a = i_in_data; m_s = i_in_signed; m_ph = PH_B;
                    end
                    PH_B: if (i_in_valid) begin
                        m_b = i_in_data; m_wait = SETTLE; m_ph = PH_WAIT;
                    end
                    PH_WAIT: begin
                        m_wait--;
                        if (m_wait == 0) begin
                            m_true = ref_mul(m_a, m_b, m_s);
                            m_p = corrupt ? 16'h0000 : m_true;
`ifdef B_MULT_SEQ_CHECK_EN
                            if (m_p != m_true) m_err = 1'b1;
`endif
                            m_ph = PH_LO;
                        end
                    end
                    PH_LO: if (i_out_ready) m_ph = PH_HI;
                    PH_HI: if (i_out_ready) m_ph = PH_A;
                    default: m_ph = PH_A;
                endcase
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic s);
        logic acc;
        int   k;
        acc = 1'b0; k = 0;
        i_in_valid = 1'b1; i_in_data = d; i_in_signed = s;
        while (!acc && k < 100) begin
            @(negedge clk); acc = o_in_ready; k++;
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic pull(output logic [7:0] d, output logic last, output int waited);
        logic got;
        got = 1'b0; waited = 0; d = 8'h00; last = 1'b0;
        i_out_ready = 1'b1;
        while (!got && waited < 100) begin
            @(negedge clk); waited++;
            if (o_out_valid) begin
                d = o_out_data; last = o_out_last; got = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!got) chk("pull_timeout", 32'(0), 32'(1));
    endtask

    task automatic txn(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] e_lo, input logic [7:0] e_hi);
        logic [7:0] d;
        logic       last;
        int         w;
        push(a, s);
        push(b, s);
        pull(d, last, w);
        chk({name, "_lat"}, 32'(w), 32'(SETTLE + 1));
        chk({name, "_lo"}, 32'(d), 32'(e_lo));
        chk({name, "_lo_last"}, 32'(last), 32'(0));
        pull(d, last, w);
        chk({name, "_hi_lat"}, 32'(w), 32'(1));
        chk({name, "_hi"}, 32'(d), 32'(e_hi));
        chk({name, "_hi_last"}, 32'(last), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       last;
        int         w;
        n_checks = 0; n_errors = 0;
        corrupt = 1'b0;
        rst_n = 1'b0; i_ena = 1'b1; i_in_valid = 1'b0; i_in_data = 8'h00;
        i_in_signed = 1'b0; i_out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 32'(o_in_ready), 32'(1));
        chk("rst_busy", 32'(o_busy), 32'(0));
        chk("rst_out_valid", 32'(o_out_valid), 32'(0));
        chk("rst_mul_a", 32'(o_mul_a), 32'(0));
        chk("rst_mul_b", 32'(o_mul_b), 32'(0));
        chk("rst_err", 32'(o_err), 32'(0));
        @(posedge clk); #1;

        txn("s_fd_05", 8'hFD, 8'h05, 1'b1, 8'hF1, 8'hFF);
        txn("u_fd_05", 8'hFD, 8'h05, 1'b0, 8'hF1, 8'h04);
        txn("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE);
        txn("s_80_80", 8'h80, 8'h80, 1'b1, 8'h00, 8'h40);

        // Back-pressure in OUT_LO.
        i_out_ready = 1'b0;
        push(8'hFD, 1'b1);
        push(8'h05, 1'b1);
        w = 0;
        while (!o_out_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(o_out_valid), 32'(1));
            chk("hold_data", 32'(o_out_data), 32'(8'hF1));
            @(posedge clk); #1;
        end
        pull(d, last, w);
        chk("hold_lo", 32'(d), 32'(8'hF1));
        pull(d, last, w);
        chk("hold_hi", 32'(d), 32'(8'hFF));

        // Enable dropped for 3 cycles during SETTLE.
        push(8'h03, 1'b0);
        push(8'h04, 1'b0);
        i_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        i_ena = 1'b1;
        pull(d, last, w);
        chk("ena_lat", 32'(w + 3), 32'(SETTLE + 1 + 3));
        chk("ena_lo", 32'(d), 32'(8'h0C));
        pull(d, last, w);
        chk("ena_hi", 32'(d), 32'(8'h00));

        // Reset while in OUT_HI.
        push(8'h12, 1'b0);
        push(8'h34, 1'b0);
        pull(d, last, w);
        chk("rsthi_lo", 32'(d), 32'(8'ha8));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsthi_out_valid", 32'(o_out_valid), 32'(0));
        chk("rsthi_out_data", 32'(o_out_data), 32'(0));
        chk("rsthi_busy", 32'(o_busy), 32'(0));
        chk("rsthi_mul_a", 32'(o_mul_a), 32'(0));
        chk("rsthi_in_ready", 32'(o_in_ready), 32'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn("post_rst", 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE);

`ifdef B_MULT_SEQ_CHECK_EN
        corrupt = 1'b1;
        push(8'h03, 1'b0);
        push(8'h03, 1'b0);
        pull(d, last, w);
        pull(d, last, w);
        corrupt = 1'b0;
        chk("chk_err_set", 32'(o_err), 32'(1));
        txn("chk_after", 8'h02, 8'h02, 1'b0, 8'h04, 8'h00);
        chk("chk_err_sticky", 32'(o_err), 32'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            i_ena       = ($urandom_range(0, 9) != 0);
            i_in_valid  = ($urandom_range(0, 9) < 6);
            i_in_data   = 8'($urandom);
            i_in_signed = 1'($urandom);
            i_out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; i_ena = 1'b1; i_in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/b_mult_sequencer.md
# b_mult_sequencer

Sequencing controller for the 8x8 Baugh-Wooley array multiplier datapath. It accepts two operand bytes and a signed/unsigned mode from a byte-wide valid/ready host port, and drives them onto the combinational array. It waits a fixed settle time, captures the 16-bit product, then streams the product back as two bytes, low byte first. It sits between the top-level pin logic and the multiplier array.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges between operand B acceptance and product capture. Legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  design enable; low freezes all state.
- `in_valid`  in  1  host presents an operand byte.
- `in_ready`  out  1  block accepts an operand byte this cycle.
- `in_data`  in  8  operand byte.
- `in_signed`  in  1  mode, sampled with operand A: 1 = two's-complement, 0 = unsigned.
- `out_valid`  out  1  product byte available.
- `out_ready`  in  1  host consumes the product byte.
- `out_data`  out  8  product byte.
- `out_last`  out  1  high with the high product byte.
- `mul_a`, `mul_b`  out  8 each  registered operands to the array.
- `mul_signed`  out  1  registered mode to the array.
- `mul_p`  in  16  combinational array product.
- `busy`  out  1  high in any state other than LOAD_A.
- `err`  out  1  sticky self-check mismatch (see Configuration).

## Operation
- FSM states are LOAD_A, LOAD_B, SETTLE, OUT_LO, OUT_HI.
- Accept means `in_valid && in_ready` at an edge.
- Send means `out_valid && out_ready` at an edge.
- `in_ready` = `ena` and (state is LOAD_A or LOAD_B). It is combinational.
- `out_valid` = `ena` and (state is OUT_LO or OUT_HI). It is combinational.
- LOAD_A, on accept:
  - `mul_a` <= `in_data`; `mul_signed` <= `in_signed`.
  - Go to LOAD_B.
- LOAD_B, on accept:
  - `mul_b` <= `in_data`.
  - Settle counter <= `SETTLE_CYCLES`-1.
  - Go to SETTLE.
  - `in_signed` is ignored in LOAD_B.
- SETTLE:
  - If counter ≠ 0, decrement it.
  - If counter = 0, product register <= `mul_p` and go to OUT_LO.
- OUT_LO: `out_data` = product[7:0] and `out_last` = 0. On send, go to OUT_HI.
- OUT_HI: `out_data` = product[15:8] and `out_last` = 1. On send, go to LOAD_A.
- In any other state, `out_data` and `out_last` are 0.
- While `out_ready` is low, the FSM holds and `out_data` stays stable.
- `mul_a`, `mul_b` and `mul_signed` stay stable from acceptance until the next LOAD_A accept. They are never cleared between transactions.
- `ena` low:
  - No state, counter or register updates.
  - `in_ready` = 0 and `out_valid` = 0.
  - The FSM resumes unchanged when `ena` returns high.
- The product is taken verbatim from the array. The block performs no arithmetic on it, except the self-check.

## Timing
- Reset (asynchronous assert, released synchronously by the top level) puts every output at 0:
  - state LOAD_A, counter 0, product register 0;
  - `mul_a` = `mul_b` = 0, `mul_signed` = 0, `busy` = 0, `err` = 0.
  - `in_ready` = `ena` immediately after reset.
- Reset mid-transaction aborts it. Partial operands are discarded and no output byte is produced.
- Operand B accepted at edge E0: the product is captured at edge E(`SETTLE_CYCLES`). `out_valid` rises in the following cycle.
- With `out_ready` held high, the low byte is sent at E(S+1) and the high byte at E(S+2). `in_ready` rises after E(S+2).
- Best-case throughput is one product per `SETTLE_CYCLES`+4 cycles.
- There is no overlap: a new operand A cannot be accepted before the high byte is sent.
- `in_valid` while not ready has no effect. Data is not buffered.

## Configuration
- `B_MULT_SEQ_CHECK_EN` defined:
  - At the capture edge, the block compares `mul_p` against an internal behavioural product.
  - The behavioural product is the signed or unsigned 8x8 product according to `mul_signed`.
  - On a mismatch, `err` is set. It stays set until reset.
  - The captured product is still the `mul_p` value.
- `B_MULT_SEQ_CHECK_EN` undefined: `err` is tied to 0 and no checker logic is synthesized.

## Test plan
- Reset with `ena`=1 → `in_ready`=1, `busy`=0, `out_valid`=0, `mul_a`=`mul_b`=0, `err`=0.
- Signed 0xFD × 0x05, `out_ready`=1, S=2 → bytes 0xF1 (`out_last`=0), then 0xFF (`out_last`=1); `out_valid` first high the cycle after E2.
- Unsigned 0xFD × 0x05 → 0xF1, then 0x04.
- Unsigned 0xFF × 0xFF → 0x01, then 0xFE.
- Signed 0x80 × 0x80 → 0x00, then 0x40.
- `out_ready` held low 5 cycles in OUT_LO → `out_data`=0xF1 stable with `out_valid`=1.
- `ena` dropped 3 cycles in SETTLE → capture delayed exactly 3 cycles.
- `rst_n` pulsed in OUT_HI → outputs return to 0 and the next pair is processed normally.
- With `B_MULT_SEQ_CHECK_EN`: force `mul_p` to 0x0000 for 3×3 → `err`=1, which stays 1 through a later correct transaction.
